// File: rtl/porta_entrada_fifo.sv
// Memory-mapped input port: a producer pushes bytes into a small FIFO over
// valid/ready, and the processor pops them through a data address and polls
// (and W1C-clears) sticky overflow/underflow flags through a status address.
module porta_entrada_fifo #(
  parameter logic [7:0]  END_DADOS  = 8'hF0,
  parameter logic [7:0]  END_STATUS = 8'hF1,
  parameter int unsigned PROF_LOG2  = 2,
  parameter int unsigned ESPERA_MAX = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] endereco,
  input  logic       leitura,
  input  logic       write,
  input  logic [7:0] dado_in,
  output logic [7:0] dado_out,
  output logic       sel,
  input  logic [7:0] dado_ext,
  input  logic       valido_ext,
  output logic       pronto_ext
);

  localparam int unsigned DW   = 8;
  localparam int unsigned PROF = 1 << PROF_LOG2;
  localparam int unsigned CW   = PROF_LOG2 + 1;
  localparam int unsigned EW   = 8;

  logic [PROF_LOG2-1:0] wptr_q, wptr_d;
  logic [PROF_LOG2-1:0] rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [EW-1:0]        espera_q, espera_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic [DW-1:0]        mem_q [PROF];

  logic full, empty, push, pop_req, pop, udf_set, stall, ovf_set, wr_status;

  // Only the two flag-clear bits of a status write carry meaning.
  logic unused_dado_in;
  assign unused_dado_in = ^dado_in[5:0];

  // Handshake and strobe decode, all from registered state.
  assign full       = (count_q == CW'(PROF));
  assign empty      = (count_q == '0);
  assign pronto_ext = reset & ~full;
  assign push       = valido_ext & pronto_ext;
  assign pop_req    = leitura & (endereco == END_DADOS);
  assign pop        = pop_req & ~empty;
  assign udf_set    = pop_req & empty;
  assign stall      = valido_ext & ~pronto_ext;
  assign ovf_set    = stall & (espera_q == EW'(ESPERA_MAX - 1));
  assign wr_status  = write & (endereco == END_STATUS);

  // Next-state: pointers, occupancy, stall counter and sticky flags.
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    espera_d = '0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (push) wptr_d = wptr_q + PROF_LOG2'(1);
    if (pop)  rptr_d = rptr_q + PROF_LOG2'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (stall) begin
      espera_d = (espera_q == EW'(ESPERA_MAX)) ? espera_q : espera_q + EW'(1);
    end

    // Clear first so a same-cycle set takes priority.
    if (wr_status && dado_in[7]) ovf_d = 1'b0;
    if (wr_status && dado_in[6]) udf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
    if (udf_set) udf_d = 1'b1;
  end

  // Control state register; storage is deliberately left out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      espera_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      espera_q <= espera_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // FIFO storage write on accepted push.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= dado_ext;
  end

  // Combinational read mux onto the shared memory read path.
  always_comb begin
    dado_out = '0;
    sel      = 1'b0;
    if (endereco == END_DADOS) begin
      sel = 1'b1;
      if (!empty) dado_out = mem_q[rptr_q];
    end else if (endereco == END_STATUS) begin
      sel      = 1'b1;
      dado_out = {ovf_q, udf_q, full, empty, 1'b0, 3'(count_q)};
    end
  end

endmodule

// File: tb/tb_porta_entrada_fifo.sv
// Bench for porta_entrada_fifo: read transactions push their expected byte
// into a scoreboard queue; a monitor checks dado_out on every read strobe.
module tb_porta_entrada_fifo;

  logic       clock;
  logic       reset;
  logic [7:0] endereco;
  logic       leitura;
  logic       write;
  logic [7:0] dado_in;
  logic [7:0] dado_out;
  logic       sel;
  logic [7:0] dado_ext;
  logic       valido_ext;
  logic       pronto_ext;

  localparam logic [7:0] AD = 8'hF0;
  localparam logic [7:0] AS = 8'hF1;

  int total = 0;
  int bad   = 0;
  int rd_id = 0;

  typedef struct {
    int         id;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  porta_entrada_fifo dut (
    .clock(clock), .reset(reset), .endereco(endereco), .leitura(leitura),
    .write(write), .dado_in(dado_in), .dado_out(dado_out), .sel(sel),
    .dado_ext(dado_ext), .valido_ext(valido_ext), .pronto_ext(pronto_ext)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Monitor: every read strobe consumes one scoreboard entry.
  always @(negedge clock) begin
    if (leitura === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got %02h expected none", dado_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("read#%0d", e.id), dado_out, e.val);
        chk($sformatf("sel#%0d", e.id), 8'(sel), 8'h01);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic rd(input logic [7:0] a, input logic [7:0] exp);
    exp_t e;
    e.id  = rd_id++;
    e.val = exp;
    sb.push_back(e);
    endereco = a;
    leitura  = 1'b1;
    @(posedge clock); #1;
    leitura  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    endereco = a;
    dado_in  = d;
    write    = 1'b1;
    @(posedge clock); #1;
    write    = 1'b0;
  endtask

  task automatic push4(input logic [7:0] b0, b1, b2, b3);
    logic [7:0] v [4];
    v[0] = b0; v[1] = b1; v[2] = b2; v[3] = b3;
    for (int i = 0; i < 4; i++) begin
      dado_ext   = v[i];
      valido_ext = 1'b1;
      @(posedge clock); #1;
    end
    valido_ext = 1'b0;
  endtask

  task automatic hold_valid(input int n);
    dado_ext   = 8'hEE;
    valido_ext = 1'b1;
    repeat (n) @(posedge clock);
    #1;
    valido_ext = 1'b0;
  endtask

  initial begin
    reset = 1'b1; endereco = 8'h00; leitura = 1'b0; write = 1'b0;
    dado_in = 8'h00; dado_ext = 8'h00; valido_ext = 1'b0;
    #3 reset = 1'b0;
    #4 chk("pronto_in_reset", 8'(pronto_ext), 8'h00);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    // Idle after reset.
    chk("pronto_idle", 8'(pronto_ext), 8'h01);
    rd(AS, 8'h10);
    endereco = 8'h00;
    #1 chk("sel_other", 8'(sel), 8'h00);
    chk("data_other", dado_out, 8'h00);

    // Fill then drain in order.
    push4(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    chk("pronto_full", 8'(pronto_ext), 8'h00);
    rd(AS, 8'h24);
    rd(AD, 8'hA1); rd(AD, 8'hB2); rd(AD, 8'hC3); rd(AD, 8'hD4);
    rd(AS, 8'h10);

    // Full with same-cycle pop and offered byte; E5 lands one cycle later.
    push4(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    begin
      exp_t e;
      e.id = rd_id++; e.val = 8'hA1; sb.push_back(e);
    end
    endereco = AD; leitura = 1'b1; dado_ext = 8'hE5; valido_ext = 1'b1;
    @(posedge clock); #1;
    leitura = 1'b0;
    chk("pronto_after_pop", 8'(pronto_ext), 8'h01);
    @(posedge clock); #1;
    valido_ext = 1'b0;
    rd(AS, 8'h24);
    rd(AD, 8'hB2); rd(AD, 8'hC3); rd(AD, 8'hD4); rd(AD, 8'hE5);
    rd(AS, 8'h10);

    // Underflow on empty, then W1C clear.
    rd(AD, 8'h00);
    rd(AS, 8'h50);
    wr(AS, 8'h40);
    rd(AS, 8'h10);

    // Empty with same-cycle push and pop: no bypass, udf sets, push accepted.
    dado_ext = 8'h77; valido_ext = 1'b1;
    rd(AD, 8'h00);
    valido_ext = 1'b0;
    rd(AS, 8'h41);
    wr(AD, 8'hC0);
    rd(AS, 8'h41);
    wr(AS, 8'h40);
    rd(AS, 8'h01);
    rd(AD, 8'h77);
    rd(AS, 8'h10);

    // Stall counter: 15 cycles no flag, 16 cycles sets ovf, W1C clears it.
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    hold_valid(15);
    rd(AS, 8'h24);
    hold_valid(16);
    rd(AS, 8'hA4);
    wr(AS, 8'h80);
    rd(AS, 8'h24);
    rd(AD, 8'h11); rd(AD, 8'h22); rd(AD, 8'h33); rd(AD, 8'h44);
    rd(AS, 8'h10);

    // Reset mid-push discards contents and in-flight byte.
    dado_ext = 8'h55; valido_ext = 1'b1;
    @(posedge clock); #1;
    dado_ext = 8'h66;
    @(posedge clock); #1;
    dado_ext = 8'h99;
    #2 reset = 1'b0;
    #1 chk("pronto_mid_reset", 8'(pronto_ext), 8'h00);
    @(posedge clock); #1;
    chk("pronto_held_reset", 8'(pronto_ext), 8'h00);
    valido_ext = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    rd(AS, 8'h10);
    rd(AD, 8'h00);
    rd(AS, 8'h50);

    repeat (2) @(posedge clock);
    chk("scoreboard_empty", 8'(sb.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
